// File: rtl/imem_ctrl_if.sv
// rtl/imem_ctrl_if.sv - fetch-side and backing-memory signals of the instruction-memory controller
interface imem_ctrl_if;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] instr;
    logic        imem_ready;
    logic        imem_fault;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // master: fetch stage plus backing memory; slave: the controller
    modport master (
        output addr, stall, mem_rdata, mem_ack,
        input  instr, imem_ready, imem_fault, mem_req, mem_addr
    );
    modport slave (
        input  addr, stall, mem_rdata, mem_ack,
        output instr, imem_ready, imem_fault, mem_req, mem_addr
    );
endinterface

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction-memory controller: one req/ack per fetch, redirect discard, sticky fault
module imem_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    imem_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      req_addr_q;
    logic [31:0]      data_q;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    logic             timeout_hit;

    assign hit         = (bus.addr == req_addr_q);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            req_addr_q <= '0;
            data_q     <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.addr[1:0] != 2'b00) begin
                        state <= S_FAULT;
                    end else begin
                        req_addr_q <= bus.addr;
                        mem_addr_q <= {bus.addr[31:2], 2'b00};
                        mem_req_q  <= 1'b1;
                        cnt        <= '0;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        data_q    <= bus.mem_rdata;
                        mem_req_q <= 1'b0;
                        state     <= S_VALID;
                    end else begin
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                        if (timeout_hit) begin
                            mem_req_q <= 1'b0;
                            state     <= S_FAULT;
                        end
                    end
                end
                S_VALID: begin
                    // a tag mismatch means fetch was redirected while the request was in flight
                    if (!hit) begin
                        data_q <= '0;
                        state  <= S_IDLE;
                    end else if (!bus.stall) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state     <= S_FAULT;
                end
            endcase
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.imem_ready = (state == S_VALID) && hit;
    assign bus.instr      = ((state == S_VALID) && hit) ? data_q : 32'h0;
    assign bus.imem_fault = (state == S_FAULT);
endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - directed self-checking bench for imem_ctrl
module tb_imem_ctrl;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    imem_ctrl_if ifa ();
    imem_ctrl_if ifb ();

    imem_ctrl dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    imem_ctrl #(.TIMEOUT(4), .CNT_W(9)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ifa.mem_ack = 1'b0;
        ifb.mem_ack = 1'b0;
        ifa.stall = 1'b0;
        ifb.stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.addr = 32'h100;
        ifa.mem_ack = 1'b1;
        ifa.mem_rdata = 32'hDEADBEEF;
        tick();
        tick();
        tests_run++;
        if (ifa.mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b expected 0", ifa.mem_req); end
        tests_run++;
        if (ifa.imem_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", ifa.imem_ready); end
        tests_run++;
        if (ifa.instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h expected 0", ifa.instr); end
        tests_run++;
        if (ifa.imem_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b expected 0", ifa.imem_fault); end
        tests_run++;
        if (ifa.mem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h expected 0", ifa.mem_addr); end
        // ack held high in the first cycle after reset must not complete anything
        rst = 1'b0;
        tick();
        tests_run++;
        if (ifa.imem_ready !== 1'b0 || ifa.mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ack: ready=%b mem_req=%b expected ready=0 mem_req=1", ifa.imem_ready, ifa.mem_req);
        end
    endtask

    task automatic test_zero_wait();
        apply_reset();
        ifa.addr = 32'h100;
        ifa.mem_rdata = 32'h00500093;
        ifa.mem_ack = 1'b1;
        tick();
        tests_run++;
        if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h100 || ifa.imem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zw_req: mem_req=%b mem_addr=%h ready=%b expected 1/100/0", ifa.mem_req, ifa.mem_addr, ifa.imem_ready);
        end
        tick();
        ifa.mem_ack = 1'b0;
        tests_run++;
        if (ifa.imem_ready !== 1'b1 || ifa.instr !== 32'h00500093) begin
            tests_failed++;
            $display("FAIL zw_valid: ready=%b instr=%h expected 1/00500093", ifa.imem_ready, ifa.instr);
        end
        tests_run++;
        if (ifa.mem_req !== 1'b0) begin tests_failed++; $display("FAIL zw_req_drop: got %b expected 0", ifa.mem_req); end
        tick();
        ifa.addr = 32'h104;
        tests_run++;
        if (ifa.imem_ready !== 1'b0 || ifa.instr !== 32'h0 || ifa.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL zw_idle: ready=%b instr=%h mem_req=%b expected 0/0/0", ifa.imem_ready, ifa.instr, ifa.mem_req);
        end
    endtask

    task automatic test_wait_stall();
        apply_reset();
        ifa.addr = 32'h104;
        ifa.mem_rdata = 32'h12345678;
        tick();
        for (int i = 1; i <= 5; i++) begin
            tests_run++;
            if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h104 || ifa.imem_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL ws_req_cycle%0d: mem_req=%b mem_addr=%h ready=%b expected 1/104/0", i, ifa.mem_req, ifa.mem_addr, ifa.imem_ready);
            end
            ifa.mem_ack = (i == 5);
            tick();
        end
        ifa.mem_ack = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ifa.stall = (j < 3);
            tests_run++;
            if (ifa.imem_ready !== 1'b1 || ifa.instr !== 32'h12345678 || ifa.mem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL ws_valid%0d: ready=%b instr=%h mem_req=%b expected 1/12345678/0", j, ifa.imem_ready, ifa.instr, ifa.mem_req);
            end
            tick();
        end
        ifa.stall = 1'b0;
        tests_run++;
        if (ifa.imem_ready !== 1'b0 || ifa.mem_req !== 1'b0 || ifa.imem_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL ws_idle: ready=%b mem_req=%b fault=%b expected 0/0/0", ifa.imem_ready, ifa.mem_req, ifa.imem_fault);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        ifa.addr = 32'h100;
        tick();
        ifa.addr = 32'h200;
        tick();
        tests_run++;
        if (ifa.mem_addr !== 32'h100 || ifa.mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_inflight: mem_addr=%h mem_req=%b expected 100/1", ifa.mem_addr, ifa.mem_req);
        end
        ifa.mem_ack = 1'b1;
        ifa.mem_rdata = 32'hAAAA0001;
        tick();
        ifa.mem_ack = 1'b0;
        tests_run++;
        if (ifa.imem_ready !== 1'b0 || ifa.instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL rd_stale: ready=%b instr=%h expected 0/0", ifa.imem_ready, ifa.instr);
        end
        tick();
        tests_run++;
        if (ifa.imem_ready !== 1'b0 || ifa.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_idle: ready=%b mem_req=%b expected 0/0", ifa.imem_ready, ifa.mem_req);
        end
        tick();
        tests_run++;
        if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL rd_refetch: mem_req=%b mem_addr=%h expected 1/200", ifa.mem_req, ifa.mem_addr);
        end
        ifa.mem_ack = 1'b1;
        ifa.mem_rdata = 32'hBBBB0002;
        tick();
        ifa.mem_ack = 1'b0;
        tests_run++;
        if (ifa.imem_ready !== 1'b1 || ifa.instr !== 32'hBBBB0002) begin
            tests_failed++;
            $display("FAIL rd_ready: ready=%b instr=%h expected 1/BBBB0002", ifa.imem_ready, ifa.instr);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        ifb.addr = 32'h300;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tests_run++;
            if (ifb.mem_req !== 1'b1 || ifb.imem_fault !== 1'b0) begin
                tests_failed++;
                $display("FAIL to_req_cycle%0d: mem_req=%b fault=%b expected 1/0", i, ifb.mem_req, ifb.imem_fault);
            end
            tick();
        end
        tests_run++;
        if (ifb.mem_req !== 1'b0 || ifb.imem_fault !== 1'b1 || ifb.imem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_fault: mem_req=%b fault=%b ready=%b expected 0/1/0", ifb.mem_req, ifb.imem_fault, ifb.imem_ready);
        end
        ifb.mem_ack = 1'b1;
        tick();
        tick();
        tests_run++;
        if (ifb.imem_fault !== 1'b1 || ifb.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_sticky: fault=%b mem_req=%b expected 1/0", ifb.imem_fault, ifb.mem_req);
        end
        rst = 1'b1;
        ifb.mem_ack = 1'b0;
        tick();
        rst = 1'b0;
        tests_run++;
        if (ifb.imem_fault !== 1'b0) begin tests_failed++; $display("FAIL to_rst_clear: got %b expected 0", ifb.imem_fault); end
    endtask

    task automatic test_misaligned();
        apply_reset();
        ifa.addr = 32'h102;
        tick();
        tests_run++;
        if (ifa.mem_req !== 1'b0 || ifa.imem_fault !== 1'b1 || ifa.imem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_fault: mem_req=%b fault=%b ready=%b expected 0/1/0", ifa.mem_req, ifa.imem_fault, ifa.imem_ready);
        end
        ifa.addr = 32'h100;
        ifa.mem_ack = 1'b1;
        tick();
        tick();
        tests_run++;
        if (ifa.mem_req !== 1'b0 || ifa.imem_fault !== 1'b1 || ifa.imem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_sticky: mem_req=%b fault=%b ready=%b expected 0/1/0", ifa.mem_req, ifa.imem_fault, ifa.imem_ready);
        end
        ifa.mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h11110000;
        words[1] = 32'h22220004;
        words[2] = 32'h33330008;
        apply_reset();
        ifa.mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ifa.addr = 32'h400 + 32'(k * 4);
            ifa.mem_rdata = 32'hFFFFFFFF;
            tick();
            ifa.mem_rdata = words[k];
            tick();
            ifa.mem_rdata = 32'hFFFFFFFF;
            tests_run++;
            if (ifa.imem_ready !== 1'b1 || ifa.instr !== words[k]) begin
                tests_failed++;
                $display("FAIL b2b_word%0d: ready=%b instr=%h expected 1/%h", k, ifa.imem_ready, ifa.instr, words[k]);
            end
            tick();
        end
        ifa.mem_ack = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        ifa.addr = 32'h0;
        ifa.stall = 1'b0;
        ifa.mem_rdata = 32'h0;
        ifa.mem_ack = 1'b0;
        ifb.addr = 32'h0;
        ifb.stall = 1'b0;
        ifb.mem_rdata = 32'h0;
        ifb.mem_ack = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_stall();
        test_redirect();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
